// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// op encodings, FSM state encoding, iteration count and sign helpers.
package muldiv_pkg;

    localparam int         ITER     = 32;
    localparam logic [4:0] CNT_LAST = 5'(ITER - 1);

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_FIX  = 2'b10
    } state_t;

    // Magnitude of a two's-complement word; -2^31 maps to itself, which is
    // the correct unsigned magnitude 2^31.
    function automatic logic [31:0] absVal(input logic [31:0] v);
        absVal = v[31] ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the sequencer datapath: add-and-shift-right for multiply,
// shift-left / trial-subtract / restore for divide. Purely combinational.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic        isDiv,
    input  logic [32:0] accHi,     // multiply: partial product P, divide: remainder R
    input  logic [31:0] accLo,     // multiply: multiplier, divide: dividend/quotient Q
    input  logic [31:0] operand,   // multiplicand or divisor
    output logic [32:0] nextHi,
    output logic [31:0] nextLo
);

    logic [32:0] sum_s;
    logic [32:0] shR_s;
    logic [31:0] shQ_s;
    logic [33:0] diff_s;

    // Select one add-shift or subtract-restore step depending on the op class.
    always_comb begin
        sum_s  = accHi + (accLo[0] ? {1'b0, operand} : 33'd0);
        shR_s  = {accHi[31:0], accLo[31]};
        shQ_s  = {accLo[30:0], 1'b0};
        diff_s = {1'b0, shR_s} - {2'b00, operand};
        if (isDiv) begin
            if (diff_s[33]) begin
                nextHi = shR_s;
                nextLo = shQ_s;
            end else begin
                nextHi = diff_s[32:0];
                nextLo = {shQ_s[31:1], 1'b1};
            end
        end else begin
            nextHi = {1'b0, sum_s[32:1]};
            nextLo = {sum_s[0], accLo[31:1]};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer owning the HI/LO pair.
// 32 RUN iterations plus one FIX cycle for sign correction and write-back.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             rd_hilo,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic             flush,
    output logic             stall,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t      state_r;
    logic [4:0]  cnt_r;
    logic [1:0]  opCode_r;
    logic [31:0] operand_r;
    logic [32:0] accHi_r;
    logic [31:0] accLo_r;
    logic        negQ_r;
    logic        negR_r;
    logic [31:0] opARaw_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        done_r;
    logic        divZero_r;
    logic        busy_r;

    logic [32:0] stepHi_s;
    logic [31:0] stepLo_s;
    logic        startSigned_s;
    logic [31:0] startA_s;
    logic [31:0] startB_s;
    logic [63:0] prod_s;
    logic [31:0] fixHi_s;
    logic [31:0] fixLo_s;
    logic        stall_s;

    muldiv_step uStep (
        .isDiv   (opCode_r[1]),
        .accHi   (accHi_r),
        .accLo   (accLo_r),
        .operand (operand_r),
        .nextHi  (stepHi_s),
        .nextLo  (stepLo_s)
    );

    // Operand conditioning at start: signed ops work on magnitudes.
    always_comb begin
        startSigned_s = ~op[0];
        if (startSigned_s) begin
            startA_s = absVal(opA);
            startB_s = absVal(opB);
        end else begin
            startA_s = opA;
            startB_s = opB;
        end
    end

    // Final HI/LO values produced in the FIX cycle, including divide-by-zero result.
    always_comb begin
        prod_s = {accHi_r[31:0], accLo_r};
        if (opCode_r[1]) begin
            if (divZero_r) begin
                fixHi_s = opARaw_r;
                fixLo_s = 32'hFFFF_FFFF;
            end else begin
                fixLo_s = negQ_r ? (32'd0 - accLo_r) : accLo_r;
                fixHi_s = negR_r ? (32'd0 - accHi_r[31:0]) : accHi_r[31:0];
            end
        end else begin
            if (negQ_r) begin
                prod_s = 64'd0 - prod_s;
            end else begin
                prod_s = prod_s;
            end
            fixHi_s = prod_s[63:32];
            fixLo_s = prod_s[31:0];
        end
    end

    // Pipeline freeze request; a flushed instruction never stalls.
    always_comb begin
        stall_s = 1'b0;
        if (flush) begin
            stall_s = 1'b0;
        end else begin
            stall_s = (req & ~done_r) | ((rd_hilo | wr_hi | wr_lo) & busy_r);
        end
    end

    // Sequencer FSM, iteration counter, operand registers and architectural HI/LO.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r   <= S_IDLE;
            cnt_r     <= 5'd0;
            opCode_r  <= OP_MULT;
            operand_r <= 32'd0;
            accHi_r   <= 33'd0;
            accLo_r   <= 32'd0;
            negQ_r    <= 1'b0;
            negR_r    <= 1'b0;
            opARaw_r  <= 32'd0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            done_r    <= 1'b0;
            divZero_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (wr_hi & ~flush) begin
                        hi_r <= opA;
                    end
                    if (wr_lo & ~flush) begin
                        lo_r <= opA;
                    end
                    // done blocks a restart while req is still held in the done cycle.
                    if (req & ~done_r & ~flush) begin
                        state_r   <= S_RUN;
                        busy_r    <= 1'b1;
                        cnt_r     <= 5'd0;
                        opCode_r  <= op;
                        accHi_r   <= 33'd0;
                        accLo_r   <= startA_s;
                        operand_r <= startB_s;
                        negQ_r    <= startSigned_s & (opA[31] ^ opB[31]);
                        negR_r    <= startSigned_s & opA[31];
                        opARaw_r  <= opA;
                        divZero_r <= op[1] & (opB == 32'd0);
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        state_r <= S_IDLE;
                        busy_r  <= 1'b0;
                        cnt_r   <= 5'd0;
                    end else begin
                        accHi_r <= stepHi_s;
                        accLo_r <= stepLo_s;
                        if (cnt_r == CNT_LAST) begin
                            state_r <= S_FIX;
                            cnt_r   <= 5'd0;
                        end else begin
                            cnt_r <= cnt_r + 5'd1;
                        end
                    end
                end
                S_FIX: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    if (!flush) begin
                        hi_r   <= fixHi_s;
                        lo_r   <= fixLo_s;
                        done_r <= 1'b1;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    busy_r  <= 1'b0;
                    cnt_r   <= 5'd0;
                end
            endcase
        end
    end

    assign stall    = stall_s;
    assign busy     = busy_r;
    assign done     = done_r;
    assign div_zero = divZero_r;
    assign hi       = hi_r;
    assign lo       = lo_r;

endmodule
